// File: rtl/mips_hi_lo_pkg.sv
// rtl/mips_hi_lo_pkg.sv - shared funct codes, FSM states and decode helpers for the HI/LO unit
// Purpose: definitions shared by the HI/LO multiply/divide unit and the control unit.
// Contents:
//   FUNCT_* localparams  R-type funct codes handled by the HI/LO unit
//   state_e              HI/LO unit FSM states
//   is_mult_div()        funct selects an iterative multiply/divide
//   is_signed_op()       funct selects a signed multiply/divide
package mips_hi_lo_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_e;

  function automatic logic is_mult_div(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/hi_lo_iter_core.sv
// rtl/hi_lo_iter_core.sv - iterative shift-add multiply / restoring divide datapath on magnitudes
// Purpose: RUN-phase datapath. One multiply or divide step per step_i cycle, DATA_WIDTH steps total.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   load_i       latch operands and operation, clear accumulator and step counter
//   step_i       perform one iteration step
//   is_div_i     1 = divide, 0 = multiply (sampled on load_i)
//   opa_i        multiplier / dividend magnitude (sampled on load_i)
//   opb_i        multiplicand / divisor magnitude (sampled on load_i)
//   finished_o   high during the step cycle that performs the last iteration
//   acc_o        multiply: product high half; divide: remainder magnitude
//   mq_o         multiply: product low half;  divide: quotient magnitude
module hi_lo_iter_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  is_div_i,
  input  logic [DATA_WIDTH-1:0] opa_i,
  input  logic [DATA_WIDTH-1:0] opb_i,
  output logic                  finished_o,
  output logic [DATA_WIDTH-1:0] acc_o,
  output logic [DATA_WIDTH-1:0] mq_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  // acc carries one extra bit so the multiply add-carry is kept before the shift.
  logic [W:0]    acc_q, acc_d;
  logic [W-1:0]  mq_q, mq_d;
  logic [W-1:0]  opb_q;
  logic          is_div_q;
  logic [CW-1:0] cnt_q;

  logic [W:0]    sum;
  logic [W:0]    partial;
  logic [W:0]    shifted;
  logic [W+1:0]  diff;

  always_comb begin
    acc_d   = acc_q;
    mq_d    = mq_q;
    sum     = acc_q + {1'b0, opb_q};
    partial = mq_q[0] ? sum : acc_q;
    // Remainder is always below the divisor, so its low W bits plus the next
    // dividend bit form the trial value; diff[W+1] is the borrow.
    shifted = {acc_q[W-1:0], mq_q[W-1]};
    diff    = {1'b0, shifted} - {2'b00, opb_q};
    if (is_div_q) begin
      if (diff[W+1]) begin
        acc_d = shifted;
        mq_d  = {mq_q[W-2:0], 1'b0};
      end else begin
        acc_d = diff[W:0];
        mq_d  = {mq_q[W-2:0], 1'b1};
      end
    end else begin
      acc_d = {1'b0, partial[W:1]};
      mq_d  = {partial[0], mq_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mq_q     <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else if (load_i) begin
      acc_q    <= '0;
      mq_q     <= opa_i;
      opb_q    <= opb_i;
      is_div_q <= is_div_i;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  assign finished_o = step_i && (cnt_q == LAST_STEP);
  assign acc_o      = acc_q[W-1:0];
  assign mq_o       = mq_q;

endmodule

// File: rtl/hi_lo_mult_div_unit.sv
// rtl/hi_lo_mult_div_unit.sv - iterative multiply/divide unit owning the HI/LO registers
// Purpose: executes MULT/MULTU/DIV/DIVU over DATA_WIDTH+1 busy cycles and MTHI/MTLO in one cycle.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                request from decode (mult/div/MTHI/MTLO), ignored while busy
//   funct                R-type funct code
//   operand_a            rs: multiplicand / dividend / MTHI,MTLO source
//   operand_b            rt: multiplier / divisor
//   busy                 multiply/divide in flight
//   done                 one-cycle pulse after a multiply/divide commits HI/LO
//   hi, lo               architectural HI/LO registers
module hi_lo_mult_div_unit
  import mips_hi_lo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W = DATA_WIDTH;

  state_e        state_q, state_d;
  logic [W-1:0]  hi_q, lo_q;
  logic          done_q;
  logic [W-1:0]  a_raw_q;
  logic          is_div_q, neg_res_q, neg_a_q, div_zero_q;

  logic          core_load, core_step, core_finished, commit;
  logic [W-1:0]  core_acc, core_mq;

  logic          signed_op, a_neg, b_neg;
  logic [W-1:0]  mag_a, mag_b;
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]  quo_fix, rem_fix;
  logic [W-1:0]  res_hi, res_lo;

  // Two's-complement negation of -2^(W-1) yields 2^(W-1) read as unsigned,
  // so W-bit magnitudes are exact for every signed operand.
  always_comb begin
    signed_op = is_signed_op(funct);
    a_neg     = signed_op && operand_a[W-1];
    b_neg     = signed_op && operand_b[W-1];
    mag_a     = a_neg ? -operand_a : operand_a;
    mag_b     = b_neg ? -operand_b : operand_b;
  end

  hi_lo_iter_core #(
    .DATA_WIDTH(W)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .load_i    (core_load),
    .step_i    (core_step),
    .is_div_i  (funct == FUNCT_DIV || funct == FUNCT_DIVU),
    .opa_i     (mag_a),
    .opb_i     (mag_b),
    .finished_o(core_finished),
    .acc_o     (core_acc),
    .mq_o      (core_mq)
  );

  always_comb begin
    state_d   = state_q;
    core_load = 1'b0;
    core_step = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && is_mult_div(funct)) begin
          core_load = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        core_step = 1'b1;
        if (core_finished) state_d = FIXUP;
      end
      FIXUP: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sign fix-up: product negated on differing signs, quotient likewise,
  // remainder follows the dividend. Divide-by-zero bypasses the datapath.
  always_comb begin
    prod     = {core_acc, core_mq};
    prod_fix = neg_res_q ? -prod : prod;
    quo_fix  = neg_res_q ? -core_mq : core_mq;
    rem_fix  = neg_a_q ? -core_acc : core_acc;
    if (!is_div_q) begin
      res_hi = prod_fix[2*W-1:W];
      res_lo = prod_fix[W-1:0];
    end else if (div_zero_q) begin
      res_hi = a_raw_q;
      res_lo = '1;
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_a_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= commit;
      if (core_load) begin
        a_raw_q    <= operand_a;
        is_div_q   <= (funct == FUNCT_DIV || funct == FUNCT_DIVU);
        neg_res_q  <= a_neg ^ b_neg;
        neg_a_q    <= a_neg;
        div_zero_q <= (operand_b == '0);
      end
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state_q == IDLE && start) begin
        if (funct == FUNCT_MTHI) hi_q <= operand_a;
        if (funct == FUNCT_MTLO) lo_q <= operand_a;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hi_lo_mult_div_unit.sv
// tb/tb_hi_lo_mult_div_unit.sv - directed table-driven bench for hi_lo_mult_div_unit
module tb_hi_lo_mult_div_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] operand_a, operand_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mdl_hi, mdl_lo;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs[12];

  hi_lo_mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct    (funct),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issues one mult/div, optionally injecting a second (ignored) request
  // inject_at busy cycles into the run, then checks latency, done and HI/LO.
  task automatic run_op(input string nm, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int inject_at);
    int  bc;
    bit  stable;
    start = 1'b1; funct = f; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    stable = 1'b1;
    while (busy && bc < 100) begin
      bc++;
      if (hi !== mdl_hi || lo !== mdl_lo) stable = 1'b0;
      if (bc == inject_at) begin
        start = 1'b1; funct = F_DIVU; operand_a = 32'd100; operand_b = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, " busy_cycles"}, 32'(bc), 32'd33);
    chk({nm, " hilo_stable_in_run"}, {31'd0, stable}, 32'd1);
    chk({nm, " done_pulse"}, {31'd0, done}, 32'd1);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    @(negedge clk);
    chk({nm, " done_single"}, {31'd0, done}, 32'd0);
    mdl_hi = eh;
    mdl_lo = el;
  endtask

  initial begin
    vecs[0]  = '{F_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{F_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
    vecs[4]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{F_MULTU, 32'd6,        32'd7,        32'd0,        32'd42};
    vecs[6]  = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[7]  = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[8]  = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[10] = '{F_MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[11] = '{F_DIVU,  32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF};

    reset = 1'b1; start = 1'b0; funct = '0; operand_a = '0; operand_b = '0;
    mdl_hi = '0; mdl_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, -1);
    end

    // MTHI then back-to-back MTLO
    start = 1'b1; funct = F_MTHI; operand_a = 32'h12345678;
    @(negedge clk);
    chk("mthi hi", hi, 32'h12345678);
    chk("mthi lo_unchanged", lo, mdl_lo);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    chk("mthi done", {31'd0, done}, 32'd0);
    mdl_hi = 32'h12345678;
    funct = F_MTLO; operand_a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo lo", lo, 32'h9ABCDEF0);
    chk("mtlo hi_unchanged", hi, mdl_hi);
    chk("mtlo done", {31'd0, done}, 32'd0);
    mdl_lo = 32'h9ABCDEF0;

    // unrelated funct has no effect
    start = 1'b1; funct = F_ADD; operand_a = 32'hDEADBEEF; operand_b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    chk("other_funct busy", {31'd0, busy}, 32'd0);
    chk("other_funct hi", hi, mdl_hi);
    chk("other_funct lo", lo, mdl_lo);

    // second request while busy is ignored
    run_op("busy_ignore", F_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
    @(negedge clk);
    chk("busy_ignore no_restart", {31'd0, busy}, 32'd0);

    // reset mid-divide aborts without commit
    start = 1'b1; funct = F_DIV; operand_a = 32'd1000; operand_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    mdl_hi = '0; mdl_lo = '0;
    @(negedge clk);
    chk("abort idle", {31'd0, busy}, 32'd0);
    run_op("post_reset", F_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
